// File: rtl/xyolo_packer.sv
//==============================================================================
// Module  : xyolo_packer
// Purpose : Saturates signed layer results from the MAC/activation/maxpool
//           stage to OUT_W bits. Packs N_PACK of them into one wide word with
//           lane strobes and an incrementing word address. Buffers the words
//           in a small FIFO that feeds a valid/ready memory-write port.
//           Pulses done once the last word of the layer has been accepted.
// Ports   : clk, rst (async, active-low)
//           start/base_addr            - layer control
//           in_valid/flow_in/last      - result stream in
//           in_ready                   - result stream out
//           m_valid/m_addr/m_data/m_strb/m_ready - memory-write port
//           busy, done                 - status
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module xyolo_packer #(
    parameter int DATAPATH_W = 32,
    parameter int OUT_W      = 16,
    parameter int N_PACK     = 4,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      in_valid,
    input  logic [DATAPATH_W-1:0]     flow_in,
    input  logic                      last,
    output logic                      in_ready,
    output logic                      m_valid,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [OUT_W*N_PACK-1:0]   m_data,
    output logic [N_PACK-1:0]         m_strb,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int LANE_W = $clog2(N_PACK);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = OUT_W * N_PACK;

    // Saturation bounds expressed at the input width
    localparam logic signed [DATAPATH_W-1:0] SAT_MAX =
        {{(DATAPATH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DATAPATH_W-1:0] SAT_MIN =
        {{(DATAPATH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   pack_data;
    logic [N_PACK-1:0]   pack_strb;
    logic [ADDR_W-1:0]   addr;
    logic [OUT_W-1:0]    sat_val;
    logic [WORD_W-1:0]   merged_data;
    logic [N_PACK-1:0]   merged_strb;
    logic                accept;
    logic                push;
    logic                pop;
    logic                head_last;
    logic                done_q;

    // FIFO storage; contents need no reset because outputs are gated by count
    logic [WORD_W-1:0]   mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
    logic [N_PACK-1:0]   mem_strb [FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    //--------------------------------------------------------------------------
    // Saturation and lane merge
    //--------------------------------------------------------------------------
    always_comb begin
        sat_val = flow_in[OUT_W-1:0];
        if ($signed(flow_in) > SAT_MAX) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if ($signed(flow_in) < SAT_MIN) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    always_comb begin
        merged_data = pack_data;
        merged_strb = pack_strb;
        for (int i = 0; i < N_PACK; i++) begin
            if (lane == LANE_W'(i)) begin
                merged_data[i*OUT_W +: OUT_W] = sat_val;
                merged_strb[i]                = 1'b1;
            end
        end
    end

    // Accept is gated on any FIFO space, not just on word-completing lanes
    assign in_ready  = (state == RUN) && (count < CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && ((lane == LANE_W'(N_PACK-1)) || last);
    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign head_last = m_valid && mem_last[rd_ptr];

    assign m_data    = m_valid ? mem_data[rd_ptr] : '0;
    assign m_addr    = m_valid ? mem_addr[rd_ptr] : '0;
    assign m_strb    = m_valid ? mem_strb[rd_ptr] : '0;
    assign busy      = (state != IDLE);
    assign done      = done_q;

    //--------------------------------------------------------------------------
    // Layer FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = RUN;
            RUN:     if (accept && last)     state_nxt = DRAIN;
            DRAIN:   if (pop && head_last)   state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // done follows the handshake of the last-tagged word by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DRAIN) && pop && head_last;
        end
    end

    //--------------------------------------------------------------------------
    // Pack register, lane counter, word address
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= '0;
            pack_data <= '0;
            pack_strb <= '0;
            addr      <= '0;
        end else if ((state == IDLE) && start) begin
            lane      <= '0;
            pack_data <= '0;
            pack_strb <= '0;
            addr      <= base_addr;
        end else if (accept) begin
            if (push) begin
                lane      <= '0;
                pack_data <= '0;
                pack_strb <= '0;
                addr      <= addr + ADDR_W'(1);
            end else begin
                lane      <= lane + LANE_W'(1);
                pack_data <= merged_data;
                pack_strb <= merged_strb;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Output FIFO
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= merged_data;
            mem_addr[wr_ptr] <= addr;
            mem_strb[wr_ptr] <= merged_strb;
            mem_last[wr_ptr] <= last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xyolo_packer.sv
//==============================================================================
// Module  : tb_xyolo_packer
// Purpose : Self-checking bench for xyolo_packer. A second instance with
//           ADDR_W=4 shares the stimulus so address wrap can be observed.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_xyolo_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic        in_valid;
    logic [31:0] flow_in;
    logic        last;
    logic        in_ready;
    logic        m_valid;
    logic [11:0] m_addr;
    logic [63:0] m_data;
    logic [3:0]  m_strb;
    logic        m_ready;
    logic        busy;
    logic        done;

    logic        in_ready2;
    logic        m_valid2;
    logic [3:0]  m_addr2;
    logic [63:0] m_data2;
    logic [3:0]  m_strb2;
    logic        busy2;
    logic        done2;

    always #5 clk = ~clk;

    xyolo_packer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .flow_in(flow_in), .last(last), .in_ready(in_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_strb(m_strb),
        .m_ready(m_ready), .busy(busy), .done(done)
    );

    xyolo_packer #(.ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[3:0]),
        .in_valid(in_valid), .flow_in(flow_in), .last(last), .in_ready(in_ready2),
        .m_valid(m_valid2), .m_addr(m_addr2), .m_data(m_data2), .m_strb(m_strb2),
        .m_ready(m_ready), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
        logic [3:0]  strb;
    } word_t;

    typedef struct {
        logic [31:0] din;
        logic [15:0] lane;
    } sat_vec_t;

    word_t    q1[$];
    word_t    q2[$];
    sat_vec_t sat_tbl[8];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    logic busy_at_done = 1'b1;

    always @(posedge clk) cyc++;

    // Handshakes and done pulses are observed mid-cycle, between edges
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q1.push_back('{m_addr, m_data, m_strb});
            last_hs_cyc = cyc;
        end
        if (m_valid2 && m_ready) q2.push_back('{{8'h00, m_addr2}, m_data2, m_strb2});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (done2) done2_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t q1_at(input int i);
        word_t w;
        w = '{12'hFFF, 64'hDEAD_DEAD_DEAD_DEAD, 4'h0};
        if (i < q1.size()) w = q1[i];
        return w;
    endfunction

    function automatic word_t q2_at(input int i);
        word_t w;
        w = '{12'hFFF, 64'hDEAD_DEAD_DEAD_DEAD, 4'h0};
        if (i < q2.size()) w = q2[i];
        return w;
    endfunction

    task automatic do_start(input logic [11:0] b);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Presents one result and holds it until accepted (bounded)
    task automatic send(input logic [31:0] v, input logic l);
        logic ok;
        int   n;
        in_valid = 1'b1;
        flow_in  = v;
        last     = l;
        n        = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        last     = 1'b0;
        flow_in  = '0;
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt == prev) check("done_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        int          prev;
        int          idx;
        int          n;
        logic        acc;
        logic [63:0] held;
        logic [63:0] exp;
        word_t       w;

        sat_tbl[0] = '{32'h0001_2345, 16'h7FFF};
        sat_tbl[1] = '{32'hFFFF_0000, 16'h8000};
        sat_tbl[2] = '{32'hFFFF_FF00, 16'hFF00};
        sat_tbl[3] = '{32'h0000_0100, 16'h0100};
        sat_tbl[4] = '{32'h0000_7FFF, 16'h7FFF};
        sat_tbl[5] = '{32'hFFFF_8000, 16'h8000};
        sat_tbl[6] = '{32'h0000_8000, 16'h7FFF};
        sat_tbl[7] = '{32'hFFFF_7FFF, 16'h8000};

        rst = 1'b0; start = 1'b0; base_addr = '0; m_ready = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_m_addr",   64'(m_addr),   64'd0);
        check("rst_m_data",   m_data,        64'd0);
        check("rst_m_strb",   64'(m_strb),   64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- full words, back-to-back ----------------
        q1.delete(); q2.delete();
        prev = done_cnt;
        do_start(12'h010);
        check("start_busy", 64'(busy), 64'd1);
        check("start_in_ready", 64'(in_ready), 64'd1);
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        idle_in();
        wait_done(prev);
        repeat (3) @(posedge clk);
        #1;
        check("full_nwords", 64'(q1.size()), 64'd2);
        w = q1_at(0);
        check("full_w0_addr", 64'(w.addr), 64'h010);
        check("full_w0_data", w.data, 64'h0004_0003_0002_0001);
        check("full_w0_strb", 64'(w.strb), 64'hF);
        w = q1_at(1);
        check("full_w1_addr", 64'(w.addr), 64'h011);
        check("full_w1_data", w.data, 64'h0008_0007_0006_0005);
        check("full_w1_strb", 64'(w.strb), 64'hF);
        check("full_done_cnt", 64'(done_cnt - prev), 64'd1);
        check("full_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
        check("full_busy_at_done", 64'(busy_at_done), 64'd0);

        // ---------------- saturation table ----------------
        q1.delete(); q2.delete();
        prev = done_cnt;
        do_start(12'h020);
        for (int i = 0; i < 8; i++) send(sat_tbl[i].din, i == 7);
        idle_in();
        wait_done(prev);
        check("sat_nwords", 64'(q1.size()), 64'd2);
        for (int i = 0; i < 8; i++) begin
            w = q1_at(i / 4);
            check($sformatf("sat_lane%0d", i), 64'(w.data[(i%4)*16 +: 16]), 64'(sat_tbl[i].lane));
        end
        check("sat_w1_strb", 64'(q1_at(1).strb), 64'hF);

        // ---------------- partial last word ----------------
        q1.delete(); q2.delete();
        prev = done_cnt;
        do_start(12'h030);
        for (int i = 1; i <= 6; i++) send(32'(i), i == 6);
        idle_in();
        wait_done(prev);
        check("part_nwords", 64'(q1.size()), 64'd2);
        w = q1_at(1);
        check("part_w1_addr", 64'(w.addr), 64'h031);
        check("part_w1_data", w.data, 64'h0000_0000_0006_0005);
        check("part_w1_strb", 64'(w.strb), 64'h3);
        check("part_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);

        // ---------------- backpressure ----------------
        q1.delete(); q2.delete();
        prev = done_cnt;
        m_ready = 1'b0;
        do_start(12'h040);
        idx = 0; n = 0; held = '0;
        in_valid = 1'b1; flow_in = 32'd1; last = 1'b0;
        while (idx < 20 && n < 400) begin
            @(negedge clk);
            acc = in_ready;
            if (n == 20) held = m_data;
            if (n == 29) begin
                check("bp_accepted", 64'(idx), 64'd16);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_m_valid", 64'(m_valid), 64'd1);
                check("bp_head_addr", 64'(m_addr), 64'h040);
                check("bp_head_data", m_data, 64'h0004_0003_0002_0001);
                check("bp_head_stable", m_data, held);
            end
            @(posedge clk); #1;
            n++;
            if (acc) begin
                idx++;
                if (idx < 20) begin
                    flow_in = 32'(idx + 1);
                    last    = (idx == 19);
                end else begin
                    idle_in();
                end
            end
            if (n == 30) m_ready = 1'b1;
        end
        idle_in();
        check("bp_all_sent", 64'(idx), 64'd20);
        wait_done(prev);
        check("bp_nwords", 64'(q1.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            w   = q1_at(k);
            exp = {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
            check($sformatf("bp_w%0d_addr", k), 64'(w.addr), 64'(12'h040 + 12'(k)));
            check($sformatf("bp_w%0d_data", k), w.data, exp);
        end

        // ---------------- address wrap (ADDR_W=4 instance) ----------------
        q1.delete(); q2.delete();
        prev = done_cnt;
        do_start(12'h00F);
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        idle_in();
        wait_done(prev);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_nwords", 64'(q2.size()), 64'd2);
        check("wrap_w0_addr", 64'(q2_at(0).addr), 64'h00F);
        check("wrap_w1_addr", 64'(q2_at(1).addr), 64'h000);
        check("wrap_w1_data", q2_at(1).data, 64'h0008_0007_0006_0005);
        check("wrap_done2", 64'(done2_cnt), 64'(done_cnt));

        // ---------------- reset mid-layer ----------------
        q1.delete(); q2.delete();
        m_ready = 1'b0;
        do_start(12'h050);
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        idle_in();
        @(posedge clk); #1;
        check("mr_queued", 64'(m_valid), 64'd1);
        prev = done_cnt;
        #2 rst = 1'b0;
        #1;
        check("mr_m_valid", 64'(m_valid), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mr_no_done", 64'(done_cnt - prev), 64'd0);
        check("mr_no_words", 64'(q1.size()), 64'd0);
        do_start(12'h020);
        for (int i = 1; i <= 4; i++) send(32'(i), i == 4);
        idle_in();
        wait_done(prev);
        check("mr_nwords", 64'(q1.size()), 64'd1);
        check("mr_w0_addr", 64'(q1_at(0).addr), 64'h020);
        check("mr_w0_data", q1_at(0).data, 64'h0004_0003_0002_0001);
        check("mr_w0_strb", 64'(q1_at(0).strb), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
